// File: rtl/interrupt_distributor.sv
// ----------------------------------------------------------------------------
// interrupt_distributor
//   Per-core interrupt distributor. Latches interrupt sources (level or rising
//   edge), routes each eligible source to exactly one hardware thread whose
//   routing mask enables it (round-robin across threads), and tracks a
//   claim/complete handshake so a source is never delivered twice while it is
//   in service.
//
//   Ports
//     clk, reset_n        core clock, asynchronous active-low reset
//     interrupt_req       raw interrupt lines (synchronous to clk)
//     trigger_type        per source: 1 = level, 0 = rising edge
//     cfg_write_en/...    routing mask write (cfg_thread, cfg_mask)
//     claim_en/...        claim request from claim_thread
//     claim_resp_*        registered claim response, one-cycle strobe
//     complete_en/...     end of service for complete_id
//     irq_pending         bit t set while any source is routed to thread t
//
//   Level requests are sampled through req_prev_q, so a level source and an
//   edge source both become routable one edge after the request is sampled.
// ----------------------------------------------------------------------------
module interrupt_distributor #(
    parameter int unsigned NUM_INTERRUPTS = 16,
    parameter int unsigned NUM_THREADS    = 4,
    parameter int unsigned ID_WIDTH       = $clog2(NUM_INTERRUPTS),
    parameter int unsigned TID_WIDTH      = $clog2(NUM_THREADS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_INTERRUPTS-1:0] interrupt_req,
    input  logic [NUM_INTERRUPTS-1:0] trigger_type,
    input  logic                      cfg_write_en,
    input  logic [TID_WIDTH-1:0]      cfg_thread,
    input  logic [NUM_INTERRUPTS-1:0] cfg_mask,
    input  logic                      claim_en,
    input  logic [TID_WIDTH-1:0]      claim_thread,
    output logic                      claim_resp_valid,
    output logic                      claim_resp_none,
    output logic [ID_WIDTH-1:0]       claim_resp_id,
    input  logic                      complete_en,
    input  logic [ID_WIDTH-1:0]       complete_id,
    output logic [NUM_THREADS-1:0]    irq_pending
);

    typedef enum logic [1:0] {
        SRC_IDLE   = 2'd0,
        SRC_ROUTED = 2'd1,
        SRC_ACTIVE = 2'd2
    } src_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_INTERRUPTS-1:0] req_prev_q, req_prev_d;
    logic [NUM_INTERRUPTS-1:0] latch_q,    latch_d;
    logic [NUM_INTERRUPTS-1:0] mask_q  [NUM_THREADS];
    logic [NUM_INTERRUPTS-1:0] mask_d  [NUM_THREADS];
    src_state_e                state_q [NUM_INTERRUPTS];
    src_state_e                state_d [NUM_INTERRUPTS];
    logic [TID_WIDTH-1:0]      owner_q [NUM_INTERRUPTS];
    logic [TID_WIDTH-1:0]      owner_d [NUM_INTERRUPTS];
    logic [TID_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;

    logic                      claim_resp_valid_q, claim_resp_valid_d;
    logic                      claim_resp_none_q,  claim_resp_none_d;
    logic [ID_WIDTH-1:0]       claim_resp_id_q,    claim_resp_id_d;
    logic [NUM_THREADS-1:0]    irq_pending_q,      irq_pending_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NUM_INTERRUPTS-1:0] edge_det;
    logic [NUM_INTERRUPTS-1:0] pending;
    logic [NUM_INTERRUPTS-1:0] any_mask;

    logic                      route_found;
    logic [ID_WIDTH-1:0]       route_id;
    logic                      owner_found;
    logic [TID_WIDTH-1:0]      route_owner;
    logic [TID_WIDTH-1:0]      scan_tid;

    logic                      claim_hit;
    logic [ID_WIDTH-1:0]       claim_id;

    // Source qualification: edge detect, per-source pending, routability.
    always_comb begin
        edge_det = interrupt_req & ~req_prev_q;
        pending  = (trigger_type & req_prev_q) | (~trigger_type & latch_q);
        any_mask = '0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            any_mask = any_mask | mask_q[TID_WIDTH'(t)];
        end
    end

    // Pick the lowest-index routable source and its round-robin owner.
    always_comb begin
        route_found = 1'b0;
        route_id    = '0;
        for (int unsigned i = 0; i < NUM_INTERRUPTS; i++) begin
            if (!route_found && (state_q[ID_WIDTH'(i)] == SRC_IDLE) &&
                pending[ID_WIDTH'(i)] && any_mask[ID_WIDTH'(i)]) begin
                route_found = 1'b1;
                route_id    = ID_WIDTH'(i);
            end
        end

        owner_found = 1'b0;
        route_owner = '0;
        scan_tid    = '0;
        for (int unsigned k = 0; k < NUM_THREADS; k++) begin
            scan_tid = TID_WIDTH'((32'(rr_ptr_q) + k) % NUM_THREADS);
            if (!owner_found && mask_q[scan_tid][route_id]) begin
                owner_found = 1'b1;
                route_owner = scan_tid;
            end
        end
    end

    // Claim selects the lowest-index source routed to the claimer.
    always_comb begin
        claim_hit = 1'b0;
        claim_id  = '0;
        for (int unsigned i = 0; i < NUM_INTERRUPTS; i++) begin
            if (claim_en && !claim_hit &&
                (state_q[ID_WIDTH'(i)] == SRC_ROUTED) &&
                (owner_q[ID_WIDTH'(i)] == claim_thread)) begin
                claim_hit = 1'b1;
                claim_id  = ID_WIDTH'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_prev_d         = interrupt_req;
        latch_d            = latch_q;
        mask_d             = mask_q;
        state_d            = state_q;
        owner_d            = owner_q;
        rr_ptr_d           = rr_ptr_q;
        claim_resp_valid_d = claim_en;
        claim_resp_none_d  = claim_en && !claim_hit;
        claim_resp_id_d    = claim_hit ? claim_id : '0;
        irq_pending_d      = '0;

        // Claim clears the latch; a simultaneous new edge keeps it set.
        if (claim_hit) begin
            latch_d[claim_id] = 1'b0;
        end
        latch_d = latch_d | edge_det;

        // Routing above already used the old mask.
        if (cfg_write_en) begin
            mask_d[cfg_thread] = cfg_mask;
        end

        if (route_found) begin
            rr_ptr_d = TID_WIDTH'((32'(route_owner) + 32'd1) % NUM_THREADS);
        end

        for (int unsigned i = 0; i < NUM_INTERRUPTS; i++) begin
            unique case (state_q[ID_WIDTH'(i)])
                SRC_IDLE: begin
                    if (route_found && (route_id == ID_WIDTH'(i))) begin
                        state_d[ID_WIDTH'(i)] = SRC_ROUTED;
                        owner_d[ID_WIDTH'(i)] = route_owner;
                    end
                end
                SRC_ROUTED: begin
                    // A claim beats a simultaneous mask withdrawal.
                    if (claim_hit && (claim_id == ID_WIDTH'(i))) begin
                        state_d[ID_WIDTH'(i)] = SRC_ACTIVE;
                    end else if ((cfg_write_en &&
                                  (cfg_thread == owner_q[ID_WIDTH'(i)]) &&
                                  !cfg_mask[ID_WIDTH'(i)]) ||
                                 (trigger_type[ID_WIDTH'(i)] &&
                                  !req_prev_q[ID_WIDTH'(i)])) begin
                        state_d[ID_WIDTH'(i)] = SRC_IDLE;
                    end
                end
                SRC_ACTIVE: begin
                    if (complete_en && (complete_id == ID_WIDTH'(i))) begin
                        state_d[ID_WIDTH'(i)] = SRC_IDLE;
                    end
                end
                default: begin
                    state_d[ID_WIDTH'(i)] = SRC_IDLE;
                end
            endcase
        end

        // Pending bitmap tracks the state registers as they will be after this edge.
        for (int unsigned i = 0; i < NUM_INTERRUPTS; i++) begin
            if (state_d[ID_WIDTH'(i)] == SRC_ROUTED) begin
                irq_pending_d[owner_d[ID_WIDTH'(i)]] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_prev_q         <= '0;
            latch_q            <= '0;
            rr_ptr_q           <= '0;
            claim_resp_valid_q <= 1'b0;
            claim_resp_none_q  <= 1'b0;
            claim_resp_id_q    <= '0;
            irq_pending_q      <= '0;
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                mask_q[TID_WIDTH'(t)] <= '0;
            end
            for (int unsigned i = 0; i < NUM_INTERRUPTS; i++) begin
                state_q[ID_WIDTH'(i)] <= SRC_IDLE;
                owner_q[ID_WIDTH'(i)] <= '0;
            end
        end else begin
            req_prev_q         <= req_prev_d;
            latch_q            <= latch_d;
            rr_ptr_q           <= rr_ptr_d;
            claim_resp_valid_q <= claim_resp_valid_d;
            claim_resp_none_q  <= claim_resp_none_d;
            claim_resp_id_q    <= claim_resp_id_d;
            irq_pending_q      <= irq_pending_d;
            mask_q             <= mask_d;
            state_q            <= state_d;
            owner_q            <= owner_d;
        end
    end

    assign claim_resp_valid = claim_resp_valid_q;
    assign claim_resp_none  = claim_resp_none_q;
    assign claim_resp_id    = claim_resp_id_q;
    assign irq_pending      = irq_pending_q;

endmodule

// File: tb/tb_interrupt_distributor.sv
// ----------------------------------------------------------------------------
// tb_interrupt_distributor
//   Directed scenarios with hand-derived expectations, followed by a
//   randomized run compared cycle by cycle against a behavioural model.
// ----------------------------------------------------------------------------
module tb_interrupt_distributor;

    localparam int NI = 16;
    localparam int NT = 4;

    logic        clk;
    logic        reset_n;
    logic [15:0] req;
    logic [15:0] trig;
    logic        cfg_we;
    logic [1:0]  cfg_thread;
    logic [15:0] cfg_mask;
    logic        claim_en;
    logic [1:0]  claim_thread;
    logic        resp_valid;
    logic        resp_none;
    logic [3:0]  resp_id;
    logic        complete_en;
    logic [3:0]  complete_id;
    logic [3:0]  irq;

    int n_cmp;
    int n_bad;

    interrupt_distributor dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .interrupt_req    (req),
        .trigger_type     (trig),
        .cfg_write_en     (cfg_we),
        .cfg_thread       (cfg_thread),
        .cfg_mask         (cfg_mask),
        .claim_en         (claim_en),
        .claim_thread     (claim_thread),
        .claim_resp_valid (resp_valid),
        .claim_resp_none  (resp_none),
        .claim_resp_id    (resp_id),
        .complete_en      (complete_en),
        .complete_id      (complete_id),
        .irq_pending      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Source status: 0 = idle, 1 = routed to m_owner, 2 = in service.
    int          m_state [NI];
    int          m_owner [NI];
    bit [15:0]   m_latch;
    bit [15:0]   m_req_prev;
    bit [15:0]   m_mask [NT];
    int          m_rr;
    bit [3:0]    m_irq;
    bit          m_valid;
    bit          m_none;
    bit [3:0]    m_id;

    task automatic model_clock();
        int        claimable[$];
        int        routable[$];
        int        claim_src;
        int        route_src;
        int        owner;
        int        nstate [NI];
        int        nowner [NI];
        bit [15:0] edges;
        bit [15:0] pend;
        bit        enabled;
        if (!reset_n) begin
            for (int i = 0; i < NI; i++) begin m_state[i] = 0; m_owner[i] = 0; end
            for (int t = 0; t < NT; t++) m_mask[t] = '0;
            m_latch = '0; m_req_prev = '0; m_rr = 0;
            m_irq = '0; m_valid = 0; m_none = 0; m_id = '0;
            return;
        end
        edges = req & ~m_req_prev;
        for (int i = 0; i < NI; i++) pend[i] = trig[i] ? m_req_prev[i] : m_latch[i];

        if (claim_en)
            for (int i = 0; i < NI; i++)
                if (m_state[i] == 1 && m_owner[i] == int'(claim_thread)) claimable.push_back(i);
        claim_src = (claimable.size() > 0) ? claimable[0] : -1;

        for (int i = 0; i < NI; i++) begin
            enabled = 0;
            for (int t = 0; t < NT; t++) enabled |= m_mask[t][i];
            if (m_state[i] == 0 && pend[i] && enabled) routable.push_back(i);
        end
        route_src = (routable.size() > 0) ? routable[0] : -1;
        owner = -1;
        if (route_src >= 0)
            for (int k = 0; k < NT; k++)
                if (owner < 0 && m_mask[(m_rr + k) % NT][route_src]) owner = (m_rr + k) % NT;

        for (int i = 0; i < NI; i++) begin
            nstate[i] = m_state[i];
            nowner[i] = m_owner[i];
            if (m_state[i] == 0 && i == route_src) begin
                nstate[i] = 1; nowner[i] = owner;
            end else if (m_state[i] == 1) begin
                if (i == claim_src) nstate[i] = 2;
                else if ((cfg_we && int'(cfg_thread) == m_owner[i] && !cfg_mask[i]) ||
                         (trig[i] && !m_req_prev[i])) nstate[i] = 0;
            end else if (m_state[i] == 2) begin
                if (complete_en && int'(complete_id) == i) nstate[i] = 0;
            end
        end

        if (claim_src >= 0) m_latch[claim_src] = 0;
        m_latch = m_latch | edges;
        if (cfg_we) m_mask[cfg_thread] = cfg_mask;
        if (route_src >= 0) m_rr = (owner + 1) % NT;
        m_req_prev = req;

        m_irq = '0;
        for (int i = 0; i < NI; i++) begin
            m_state[i] = nstate[i];
            m_owner[i] = nowner[i];
            if (nstate[i] == 1) m_irq[nowner[i]] = 1'b1;
        end
        m_valid = claim_en;
        m_none  = claim_en && (claim_src < 0);
        m_id    = (claim_src >= 0) ? 4'(claim_src) : 4'd0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = '0; trig = '0; cfg_we = 0; cfg_thread = '0; cfg_mask = '0;
        claim_en = 0; claim_thread = '0; complete_en = 0; complete_id = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic write_mask(input int t, input logic [15:0] m);
        cfg_we = 1; cfg_thread = 2'(t); cfg_mask = m;
        cycle();
        cfg_we = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        cycle();
        cycle();
        n_cmp++; if (irq !== 4'b0000) begin n_bad++; $display("FAIL reset_irq got %b exp 0000", irq); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
        n_cmp++; if (resp_none !== 1'b0) begin n_bad++; $display("FAIL reset_none got %b exp 0", resp_none); end
        n_cmp++; if (resp_id !== 4'd0) begin n_bad++; $display("FAIL reset_id got %0d exp 0", resp_id); end
        reset_n = 1'b1;
        cycle();
        n_cmp++; if (irq !== 4'b0000) begin n_bad++; $display("FAIL post_reset_irq got %b exp 0000", irq); end
    endtask

    task automatic test_level_route();
        do_reset();
        write_mask(1, 16'h0004);
        trig = 16'h0004; req = 16'h0004;
        cycle();
        n_cmp++; if (irq !== 4'b0000) begin n_bad++; $display("FAIL lvl_early irq got %b exp 0000", irq); end
        cycle();
        n_cmp++; if (irq !== 4'b0010) begin n_bad++; $display("FAIL lvl_route irq got %b exp 0010", irq); end
        claim_en = 1; claim_thread = 2'd1;
        cycle();
        claim_en = 0;
        n_cmp++; if (resp_valid !== 1'b1 || resp_none !== 1'b0) begin n_bad++; $display("FAIL lvl_claim_flags got v=%b n=%b exp v=1 n=0", resp_valid, resp_none); end
        n_cmp++; if (resp_id !== 4'd2) begin n_bad++; $display("FAIL lvl_claim_id got %0d exp 2", resp_id); end
        n_cmp++; if (irq !== 4'b0000) begin n_bad++; $display("FAIL lvl_active_irq got %b exp 0000", irq); end
        cycle();
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL lvl_strobe got %b exp 0", resp_valid); end
        complete_en = 1; complete_id = 4'd2;
        cycle();
        complete_en = 0;
        n_cmp++; if (irq !== 4'b0000) begin n_bad++; $display("FAIL lvl_complete irq got %b exp 0000", irq); end
        cycle();
        n_cmp++; if (irq !== 4'b0010) begin n_bad++; $display("FAIL lvl_reroute irq got %b exp 0010", irq); end
    endtask

    task automatic test_edge_latch();
        do_reset();
        write_mask(0, 16'hFFFF);
        req = 16'h0020;
        cycle();
        req = '0;
        n_cmp++; if (irq !== 4'b0000) begin n_bad++; $display("FAIL edge_early irq got %b exp 0000", irq); end
        cycle();
        n_cmp++; if (irq !== 4'b0001) begin n_bad++; $display("FAIL edge_route irq got %b exp 0001", irq); end
        cycle();
        cycle();
        n_cmp++; if (irq !== 4'b0001) begin n_bad++; $display("FAIL edge_persist irq got %b exp 0001", irq); end
        claim_en = 1; claim_thread = 2'd0;
        cycle();
        claim_en = 0;
        n_cmp++; if (resp_id !== 4'd5 || resp_none !== 1'b0 || resp_valid !== 1'b1) begin n_bad++; $display("FAIL edge_claim got id=%0d n=%b v=%b exp id=5 n=0 v=1", resp_id, resp_none, resp_valid); end
        req = 16'h0020;
        cycle();
        req = '0;
        cycle();
        cycle();
        n_cmp++; if (irq !== 4'b0000) begin n_bad++; $display("FAIL edge_while_active irq got %b exp 0000", irq); end
        complete_en = 1; complete_id = 4'd5;
        cycle();
        complete_en = 0;
        cycle();
        n_cmp++; if (irq !== 4'b0001) begin n_bad++; $display("FAIL edge_redeliver irq got %b exp 0001", irq); end
        claim_en = 1; claim_thread = 2'd0;
        cycle();
        claim_en = 0;
        n_cmp++; if (resp_id !== 4'd5) begin n_bad++; $display("FAIL edge_reclaim id got %0d exp 5", resp_id); end
    endtask

    task automatic test_round_robin();
        int exp_t;
        do_reset();
        for (int t = 0; t < NT; t++) write_mask(t, 16'h0008);
        for (int p = 0; p < 5; p++) begin
            exp_t = p % NT;
            req = 16'h0008;
            cycle();
            req = '0;
            cycle();
            n_cmp++; if (irq !== 4'(1 << exp_t)) begin n_bad++; $display("FAIL rr_owner pulse %0d irq got %b exp %b", p, irq, 4'(1 << exp_t)); end
            claim_en = 1; claim_thread = 2'(exp_t);
            cycle();
            claim_en = 0;
            n_cmp++; if (resp_id !== 4'd3 || resp_none !== 1'b0) begin n_bad++; $display("FAIL rr_claim pulse %0d got id=%0d n=%b exp id=3 n=0", p, resp_id, resp_none); end
            complete_en = 1; complete_id = 4'd3;
            cycle();
            complete_en = 0;
        end
    endtask

    task automatic test_priority();
        do_reset();
        write_mask(2, 16'h0090);
        req = 16'h0090;
        cycle();
        req = '0;
        cycle();
        cycle();
        n_cmp++; if (irq !== 4'b0100) begin n_bad++; $display("FAIL prio_irq got %b exp 0100", irq); end
        claim_en = 1; claim_thread = 2'd2;
        cycle();
        n_cmp++; if (resp_id !== 4'd4 || resp_none !== 1'b0) begin n_bad++; $display("FAIL prio_first got id=%0d n=%b exp id=4 n=0", resp_id, resp_none); end
        cycle();
        n_cmp++; if (resp_id !== 4'd7 || resp_none !== 1'b0) begin n_bad++; $display("FAIL prio_second got id=%0d n=%b exp id=7 n=0", resp_id, resp_none); end
        cycle();
        claim_en = 0;
        n_cmp++; if (resp_valid !== 1'b1 || resp_none !== 1'b1 || resp_id !== 4'd0) begin n_bad++; $display("FAIL prio_empty got v=%b n=%b id=%0d exp v=1 n=1 id=0", resp_valid, resp_none, resp_id); end
        cycle();
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL prio_strobe got %b exp 0", resp_valid); end
    endtask

    task automatic test_withdraw();
        do_reset();
        trig = 16'h0200;
        write_mask(1, 16'h0200);
        write_mask(3, 16'h0200);
        req = 16'h0200;
        cycle();
        cycle();
        n_cmp++; if (irq !== 4'b0010) begin n_bad++; $display("FAIL wd_route irq got %b exp 0010", irq); end
        write_mask(1, 16'h0000);
        n_cmp++; if (irq !== 4'b0000) begin n_bad++; $display("FAIL wd_drop irq got %b exp 0000", irq); end
        cycle();
        n_cmp++; if (irq !== 4'b1000) begin n_bad++; $display("FAIL wd_reroute irq got %b exp 1000", irq); end
        req = '0;
        cycle();
        cycle();
        n_cmp++; if (irq !== 4'b0000) begin n_bad++; $display("FAIL wd_level_drop irq got %b exp 0000", irq); end
        claim_en = 1; claim_thread = 2'd3;
        cycle();
        claim_en = 0;
        n_cmp++; if (resp_none !== 1'b1 || resp_valid !== 1'b1) begin n_bad++; $display("FAIL wd_claim_none got n=%b v=%b exp n=1 v=1", resp_none, resp_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        write_mask(0, 16'hFFFF);
        req = 16'h0006;
        cycle();
        req = '0;
        cycle();
        cycle();
        claim_en = 1; claim_thread = 2'd0;
        cycle();
        claim_en = 0;
        n_cmp++; if (irq !== 4'b0001 || resp_id !== 4'd1) begin n_bad++; $display("FAIL ar_setup got irq=%b id=%0d exp irq=0001 id=1", irq, resp_id); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (irq !== 4'b0000) begin n_bad++; $display("FAIL ar_irq got %b exp 0000", irq); end
        n_cmp++; if (resp_valid !== 1'b0 || resp_none !== 1'b0 || resp_id !== 4'd0) begin n_bad++; $display("FAIL ar_resp got v=%b n=%b id=%0d exp 0 0 0", resp_valid, resp_none, resp_id); end
        cycle();
        reset_n = 1'b1;
        write_mask(0, 16'hFFFF);
        complete_en = 1; complete_id = 4'd1;
        cycle();
        complete_en = 0;
        cycle();
        n_cmp++; if (irq !== 4'b0000) begin n_bad++; $display("FAIL ar_complete irq got %b exp 0000", irq); end
        claim_en = 1; claim_thread = 2'd0;
        cycle();
        claim_en = 0;
        n_cmp++; if (resp_none !== 1'b1) begin n_bad++; $display("FAIL ar_claim_none got %b exp 1", resp_none); end
    endtask

    task automatic test_random();
        int act[$];
        do_reset();
        trig = 16'($urandom);
        for (int n = 0; n < 800; n++) begin
            act.delete();
            for (int i = 0; i < NI; i++) if (m_state[i] == 2) act.push_back(i);
            if (n % 100 == 99) trig = 16'($urandom);
            req          = 16'($urandom & $urandom & $urandom);
            cfg_we       = ($urandom_range(0, 5) == 0);
            cfg_thread   = 2'($urandom_range(0, 3));
            cfg_mask     = 16'($urandom | $urandom);
            claim_en     = ($urandom_range(0, 2) == 0);
            claim_thread = 2'($urandom_range(0, 3));
            complete_en  = ($urandom_range(0, 2) == 0);
            if (act.size() > 0 && $urandom_range(0, 3) != 0)
                complete_id = 4'(act[$urandom_range(0, act.size() - 1)]);
            else
                complete_id = 4'($urandom_range(0, 15));
            cycle();
            n_cmp++; if (irq !== m_irq) begin n_bad++; $display("FAIL rnd_irq cycle %0d got %b exp %b", n, irq, m_irq); end
            n_cmp++; if (resp_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid cycle %0d got %b exp %b", n, resp_valid, m_valid); end
            n_cmp++; if (resp_none !== m_none) begin n_bad++; $display("FAIL rnd_none cycle %0d got %b exp %b", n, resp_none, m_none); end
            n_cmp++; if (resp_id !== m_id) begin n_bad++; $display("FAIL rnd_id cycle %0d got %0d exp %0d", n, resp_id, m_id); end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_level_route();
        test_edge_latch();
        test_round_robin();
        test_priority();
        test_withdraw();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
